// File: rtl/opcode_info_table.sv
// opcode_info_table: run-time loadable {map,opcode} attribute table.
// A clear sweep runs after reset. LANES channels return registered lookups.
module opcode_info_table #(
  parameter int INFO_W = 24,
  parameter int MAPS   = 2,
  parameter int LANES  = 2,
  localparam int MW    = (MAPS > 1) ? $clog2(MAPS) : 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  output logic                    init_busy,
  input  logic                    wr_en,
  output logic                    wr_ready,
  input  logic [MW-1:0]           wr_map,
  input  logic [7:0]              wr_opcode,
  input  logic [INFO_W-1:0]       wr_data,
  input  logic [LANES-1:0]        lk_valid,
  output logic [LANES-1:0]        lk_ready,
  input  logic [LANES*MW-1:0]     lk_map,
  input  logic [LANES*8-1:0]      lk_opcode,
  output logic [LANES-1:0]        rsp_valid,
  input  logic [LANES-1:0]        rsp_ready,
  output logic [LANES*INFO_W-1:0] rsp_info,
  output logic [LANES-1:0]        rsp_known,
  output logic [15:0]             miss_count
);
  localparam int DEPTH = MAPS * 256;
  localparam int AW    = MW + 8;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t          state, state_nx;
  logic [AW-1:0]   ptr, ptr_nx;
  logic [INFO_W:0] mem [DEPTH];
  logic [AW-1:0]   wa;
  logic            wr_ok, wr_go;
  logic [LANES-1:0] lk_ok, acc;
  logic [INFO_W:0] lent [LANES];
  logic [16:0]     msum;

  // Map range checks only exist when MAPS leaves unused map codes.
  if (MAPS == (1 << MW)) begin : g_full
    assign wr_ok = 1'b1;
    assign lk_ok = '1;
  end else begin : g_part
    assign wr_ok = wr_map < MW'(MAPS);
    for (genvar g = 0; g < LANES; g++) begin : g_ok
      assign lk_ok[g] = lk_map[g*MW +: MW] < MW'(MAPS);
    end
  end

  assign init_busy = (state == INIT);
  assign wr_ready  = !init_busy;
  assign wa        = {wr_map, wr_opcode};
  assign wr_go     = wr_en && wr_ready && wr_ok;

  // Sweep FSM: walk every entry once after reset, then park in RUN.
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    if (state == INIT) begin
      ptr_nx = ptr + 1'b1;
      if (ptr == LAST) state_nx = RUN;
    end
  end

  // FSM state and sweep pointer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= INIT;
      ptr   <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
    end
  end

  // Table storage: sweep clears during INIT, write port fills in RUN.
  always_ff @(posedge clk) begin
    if (init_busy) mem[ptr] <= '0;
    else if (wr_go) mem[wa] <= {1'b1, wr_data};
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [AW-1:0] la;
    assign la = {lk_map[g*MW +: MW], lk_opcode[g*8 +: 8]};
    assign lent[g] = !lk_ok[g] ? '0 :
                     (wr_go && wa == la) ? {1'b1, wr_data} :
                     mem[la];
    assign lk_ready[g] = !init_busy && (!rsp_valid[g] || rsp_ready[g]);
    assign acc[g] = lk_valid[g] && lk_ready[g];
  end

  // Miss total for this cycle, before saturation.
  always_comb begin
    msum = {1'b0, miss_count};
    for (int i = 0; i < LANES; i++) begin
      if (acc[i] && !lent[i][INFO_W]) msum = msum + 17'd1;
    end
  end

  // Response registers per lane and the saturating miss counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid  <= '0;
      rsp_info   <= '0;
      rsp_known  <= '0;
      miss_count <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (acc[i]) begin
          rsp_valid[i] <= 1'b1;
          rsp_info[i*INFO_W +: INFO_W] <= lent[i][INFO_W-1:0];
          rsp_known[i] <= lent[i][INFO_W];
        end else if (rsp_ready[i]) begin
          rsp_valid[i] <= 1'b0;
        end
      end
      miss_count <= msum[16] ? 16'hFFFF : msum[15:0];
    end
  end

endmodule
